// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive buffer: default byte width and FIFO depth.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_WIDTH      = 8;
  localparam int UART_FIFO_DEPTH_LOG2 = 4;

  // Occupancy flags derived from the wrap-extended pointers.
  typedef struct packed {
    logic empty;
    logic full;
  } fifo_flags_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read so the head is visible
// combinationally from the read pointer (first-word-fall-through).
module uart_rx_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Contents are deliberately left unreset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures a byte on each rising edge of the receiver's ready strobe and
// presents it on a FWFT read port. Define UART_RX_FIFO_OVERRUN_EN for the sticky drop flag.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
  input  logic                  I_clk,
  input  logic                  I_reset_n,
  input  logic [DATA_WIDTH-1:0] I_rx_data,
  input  logic                  I_rx_ready,
  input  logic                  I_rd_en,
  output logic [DATA_WIDTH-1:0] O_data,
  output logic                  O_empty,
  output logic                  O_full,
`ifdef UART_RX_FIFO_OVERRUN_EN
  output logic                  O_overrun,
  input  logic                  I_overrun_clr,
`endif
  output logic [DEPTH_LOG2:0]   O_count
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rx_ready_q;
  logic          wr_req, rd_fire, wr_fire;
  fifo_flags_t   flags;

  // The extra MSB distinguishes a full FIFO from an empty one when the low bits match.
  assign flags.empty = (wr_ptr_q == rd_ptr_q);
  assign flags.full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                       (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);

  assign wr_req  = I_rx_ready & ~rx_ready_q;
  assign rd_fire = I_rd_en & ~flags.empty;
  assign wr_fire = wr_req & (~flags.full | rd_fire);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rx_ready_q <= I_rx_ready;
    end
  end

  uart_rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) u_mem (
    .clk_i     (I_clk),
    .wr_en_i   (wr_fire),
    .wr_addr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wr_data_i (I_rx_data),
    .rd_addr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rd_data_o (O_data)
  );

  assign O_empty = flags.empty;
  assign O_full  = flags.full;
  assign O_count = wr_ptr_q - rd_ptr_q;

`ifdef UART_RX_FIFO_OVERRUN_EN
  logic drop;
  logic overrun_q, overrun_d;

  assign drop = wr_req & flags.full & ~rd_fire;

  // A drop coinciding with a clear keeps the flag set so the loss is never hidden.
  always_comb begin
    overrun_d = overrun_q;
    if (I_overrun_clr) overrun_d = 1'b0;
    if (drop)          overrun_d = 1'b1;
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) overrun_q <= 1'b0;
    else            overrun_q <= overrun_d;
  end

  assign O_overrun = overrun_q;
`endif

endmodule
